spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single SPI bus (SCLK/MOSI/MISO mux) between N sensor front-ends
//  (PmodALS, PmodACL2, ...). Grants exactly one requester at a time, round-robin.
//  Inserts a guard gap between owners so CS deassertion and the mux can settle.
//  Its gnt vector drives the per-device SPI clock enables, replacing the
//  ad-hoc enable toggling in the main sequencer.
// PARAMETERS
//  N_REQ        2    number of requesters, legal range 1..8
//  GUARD_CYC    2    idle cycles between release and next grant, legal range 1..255
//  TIMEOUT_CYC  4096 max cycles one owner may hold the bus (only with SPI_ARB_TIMEOUT_EN), legal range 2..2^16-1
// PORTS
//  Clock        in   1      system clock, all logic on rising edge
//  Reset        in   1      asynchronous, active-low reset
//  req          in   N_REQ  level request; held by requester until its done pulse
//  done         in   N_REQ  1-cycle pulse: requester's transaction finished
//  gnt          out  N_REQ  one-hot (or zero) registered grant = SPI clk enable
//  owner        out  W      index of current/last owner, W = max(1,$clog2(N_REQ))
//  busy         out  1      1 while in GRANT or GUARD
//  timeout_evt  out  1      1-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  - Reset (async, any state, mid-transaction included): gnt=0, owner=0, busy=0,
//    timeout_evt=0, rr pointer ptr=0, guard/timeout counters=0, state=IDLE.
//  - States: IDLE, GRANT, GUARD. All outputs registered.
//  - IDLE: if |req, choose the first set bit scanning ptr, ptr+1, ... mod N_REQ.
//    At the next edge: gnt[i]=1, owner=i, busy=1, state=GRANT.
//    Latency req->gnt = 1 cycle. req==0: stay in IDLE, gnt=0.
//  - GRANT: release when done[owner]==1 OR req[owner]==0 (abort).
//    On release, at the next edge: gnt=0, ptr=(owner+1) mod N_REQ,
//    guard counter=0, state=GUARD. owner keeps its value.
//  - GUARD: gnt=0, busy=1; counter increments each cycle.
//    After exactly GUARD_CYC cycles in GUARD, state=IDLE and busy=0.
//    Requests are sampled again only in IDLE.
//  - done bits of non-owners are ignored in all states.
//    done in IDLE or GUARD is ignored.
//  - req and done of the owner in the same cycle: done wins (normal release).
//  - A new request during GRANT/GUARD waits; no preemption.
//  - N_REQ=1: ptr is constantly 0; the GUARD gap still applies.
//  - gnt is never multi-hot; gnt==0 in IDLE and GUARD.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//  - 16-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
//  - If the TIMEOUT_CYC-th GRANT cycle has no release, force release.
//    Same transition as a normal release; timeout_evt=1 for that one cycle.
//  - A release on the same cycle as the timeout counts as normal (no timeout_evt).
//  SPI_ARB_TIMEOUT_EN undefined:
//  - No counter. GRANT is held indefinitely. timeout_evt is tied 0.
//  - TIMEOUT_CYC is ignored.
// TESTING (N_REQ=2, GUARD_CYC=2, TIMEOUT_CYC=16)
//  1 Basic grant: req=01 sampled at edge 0.
//    -> gnt=01, owner=0, busy=1 after edge 0.
//    -> done[0] pulse at edge 5: gnt=00 after edge 5; busy=0 after edge 7.
//  2 Round-robin: req=11 held from reset.
//    -> grant sequence 01,10,01,10 with each owner pulsing done.
//    -> exactly 2 gnt=00 cycles plus 1 IDLE cycle between grants.
//  3 Stray done: owner=0, pulse done[1].
//    -> gnt stays 01, ptr unchanged; next grant after done[0] still follows round-robin.
//  4 Abort: owner=1 drops req[1] with no done.
//    -> gnt=00 next edge, ptr=0; req=11 then yields gnt=01.
//  5 Timeout: req=01, never done.
//    -> with macro: gnt=00 after 16 GRANT cycles, one timeout_evt pulse.
//    -> without macro: gnt=01 held 100 cycles, timeout_evt=0.
//  6 Reset mid-GRANT (owner=1): Reset low.
//    -> gnt=00, busy=0 without a clock edge.
//    -> after release with req=11: gnt=01 (ptr reset to 0).

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// Request/grant bundle between the SPI bus arbiter and its sensor front-ends.
// master = arbiter side, slave = requester side.
interface spi_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [W-1:0]     owner;
    logic             busy;
    logic             timeout_evt;

    modport master (
        input  req,
        input  done,
        output gnt,
        output owner,
        output busy,
        output timeout_evt
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  owner,
        input  busy,
        input  timeout_evt
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbiter for the shared SPI bus with a guard gap between owners.
// Define SPI_ARB_TIMEOUT_EN to force release of an owner after TIMEOUT_CYC cycles.
module spi_bus_arbiter #(
    parameter int N_REQ       = 2,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               Clock,
    input  logic               Reset,
    spi_bus_arbiter_if.master  bus
);
    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("spi_bus_arbiter: N_REQ out of range 1..8");
    end
    if (GUARD_CYC < 1 || GUARD_CYC > 255) begin : g_bad_guard
        $error("spi_bus_arbiter: GUARD_CYC out of range 1..255");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
        $error("spi_bus_arbiter: TIMEOUT_CYC out of range 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } state_t;

    state_t           state;
    logic [W-1:0]     ptr;
    logic [W-1:0]     owner_q;
    logic [W-1:0]     pick;
    logic [W-1:0]     ptr_nxt;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] pick_oh;
    logic [7:0]       guard_cnt;
    logic             pick_vld;
    logic             own_req;
    logic             own_done;
    logic             tmo_hit;
    logic             busy_q;
    logic             tmo_q;
    logic             release_now;

    // First requester at or after ptr, wrapping; smallest distance wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (bus.req[j] && (j == (int'(ptr) + i) % N_REQ)) begin
                    pick_vld = 1'b1;
                    pick     = W'(j);
                end
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            pick_oh[j] = (pick == W'(j));
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_done = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (owner_q == W'(j)) begin
                own_req  = bus.req[j];
                own_done = bus.done[j];
            end
        end
    end

    assign ptr_nxt = (int'(owner_q) + 1 >= N_REQ) ? '0 : owner_q + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 16'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // hold_cnt is k-1 during the k-th GRANT cycle
    assign tmo_hit = (state == GRANT) &&
                     (hold_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign release_now = own_done || !own_req || tmo_hit;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ptr       <= '0;
            guard_cnt <= '0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state   <= GRANT;
                        gnt_q   <= pick_oh;
                        owner_q <= pick;
                        busy_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= GUARD;
                        gnt_q     <= '0;
                        ptr       <= ptr_nxt;
                        guard_cnt <= '0;
                        // a real release on the deadline cycle is not a timeout
                        tmo_q     <= tmo_hit && own_req && !own_done;
                    end
                end
                GUARD: begin
                    if (guard_cnt == 8'(GUARD_CYC - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_evt = tmo_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter (N_REQ=2, GUARD_CYC=2, TIMEOUT_CYC=16).
// Expected output changes are queued with their cycle; a monitor checks each change.
module tb_spi_bus_arbiter;
    logic Clock;
    logic Reset;
    int   cyc;
    int   total;
    int   bad;

    spi_bus_arbiter_if #(.N_REQ(2)) bus ();

    spi_bus_arbiter #(
        .N_REQ      (2),
        .GUARD_CYC  (2),
        .TIMEOUT_CYC(16)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        int         at;
        logic [4:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clock);
            cyc = cyc + 1;
        end
    end

    // Monitor: every change of {gnt,owner,busy,timeout_evt} must match the queue head.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge Clock);
            cur = {bus.gnt, bus.owner, bus.busy, bus.timeout_evt};
            if (cur !== prev) begin
                total = total + 1;
                if (sb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=nothing",
                             cyc, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.val !== cur || e.at != cyc) begin
                        bad = bad + 1;
                        $display("FAIL %s got=%b@%0d want=%b@%0d",
                                 e.name, cur, cyc, e.val, e.at);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expect_at(input int at, input logic [1:0] g, input logic o,
                             input logic b, input logic t, input string n);
        exp_t e;
        e.at   = at;
        e.val  = {g, o, b, t};
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic check(input string n, input logic [7:0] got, input logic [7:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    initial begin
        int g;
        int own;
        total    = 0;
        bad      = 0;
        Reset    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        tick();
        tick();
        check("rst_gnt", 8'(bus.gnt), 8'h0);
        check("rst_busy", 8'(bus.busy), 8'h0);
        check("rst_owner", 8'(bus.owner), 8'h0);
        check("rst_tmo", 8'(bus.timeout_evt), 8'h0);

        // basic grant and release with guard gap
        Reset   = 1'b1;
        bus.req = 2'b01;
        g = cyc + 1;
        expect_at(g, 2'b01, 1'b0, 1'b1, 1'b0, "t1_grant");
        wait_to(g + 5);
        bus.done = 2'b01;
        expect_at(g + 6, 2'b00, 1'b0, 1'b1, 1'b0, "t1_release");
        expect_at(g + 8, 2'b00, 1'b0, 1'b0, 1'b0, "t1_idle");
        tick();
        bus.done = '0;
        bus.req  = '0;
        wait_to(g + 9);

        // round-robin from a fresh reset with both requesting
        Reset = 1'b0;
        tick();
        Reset   = 1'b1;
        bus.req = 2'b11;
        g = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            own = k % 2;
            expect_at(g, own[0] ? 2'b10 : 2'b01, own[0], 1'b1, 1'b0, "t2_grant");
            expect_at(g + 2, 2'b00, own[0], 1'b1, 1'b0, "t2_release");
            expect_at(g + 4, 2'b00, own[0], 1'b0, 1'b0, "t2_idle");
            wait_to(g + 1);
            bus.done = own[0] ? 2'b10 : 2'b01;
            tick();
            bus.done = '0;
            if (k == 3) bus.req = '0;
            g = g + 5;
        end
        wait_to(g);

        // stray done from non-owner, then round-robin continues
        bus.req = 2'b01;
        g = cyc + 1;
        expect_at(g, 2'b01, 1'b0, 1'b1, 1'b0, "t3_grant");
        wait_to(g + 1);
        bus.done = 2'b10;
        bus.req  = 2'b11;
        tick();
        bus.done = '0;
        wait_to(g + 4);
        bus.done = 2'b01;
        expect_at(g + 5, 2'b00, 1'b0, 1'b1, 1'b0, "t3_release");
        expect_at(g + 7, 2'b00, 1'b0, 1'b0, 1'b0, "t3_idle");
        expect_at(g + 8, 2'b10, 1'b1, 1'b1, 1'b0, "t3_rr_next");
        tick();
        bus.done = '0;

        // abort by owner 1 dropping req, ptr wraps to 0
        wait_to(g + 10);
        bus.req = 2'b01;
        expect_at(g + 11, 2'b00, 1'b1, 1'b1, 1'b0, "t4_abort");
        expect_at(g + 13, 2'b00, 1'b1, 1'b0, 1'b0, "t4_idle");
        expect_at(g + 14, 2'b01, 1'b0, 1'b1, 1'b0, "t4_ptr0");
        tick();
        bus.req = 2'b11;
        wait_to(g + 15);
        bus.done = 2'b01;
        bus.req  = '0;
        expect_at(g + 16, 2'b00, 1'b0, 1'b1, 1'b0, "t4_release");
        expect_at(g + 18, 2'b00, 1'b0, 1'b0, 1'b0, "t4_idle2");
        tick();
        bus.done = '0;
        wait_to(g + 19);

        // owner never finishes
        bus.req = 2'b01;
        g = cyc + 1;
        expect_at(g, 2'b01, 1'b0, 1'b1, 1'b0, "t5_grant");
`ifdef SPI_ARB_TIMEOUT_EN
        expect_at(g + 16, 2'b00, 1'b0, 1'b1, 1'b1, "t5_timeout");
        expect_at(g + 17, 2'b00, 1'b0, 1'b1, 1'b0, "t5_evt_end");
        expect_at(g + 18, 2'b00, 1'b0, 1'b0, 1'b0, "t5_idle");
        wait_to(g + 16);
        bus.req = '0;
        wait_to(g + 19);
`else
        wait_to(g + 100);
        check("t5_hold_gnt", 8'(bus.gnt), 8'h01);
        check("t5_hold_busy", 8'(bus.busy), 8'h01);
        check("t5_no_tmo", 8'(bus.timeout_evt), 8'h00);
        bus.req = '0;
        expect_at(g + 101, 2'b00, 1'b0, 1'b1, 1'b0, "t5_release");
        expect_at(g + 103, 2'b00, 1'b0, 1'b0, 1'b0, "t5_idle");
        wait_to(g + 104);
`endif

        // async reset while owner 1 holds the bus
        bus.req = 2'b10;
        g = cyc + 1;
        expect_at(g, 2'b10, 1'b1, 1'b1, 1'b0, "t6_grant");
        wait_to(g + 2);
        expect_at(cyc, 2'b00, 1'b0, 1'b0, 1'b0, "t6_reset");
        Reset = 1'b0;
        #1;
        check("t6_gnt", 8'(bus.gnt), 8'h00);
        check("t6_busy", 8'(bus.busy), 8'h00);
        check("t6_owner", 8'(bus.owner), 8'h00);
        bus.req = 2'b11;
        tick();
        Reset = 1'b1;
        expect_at(cyc + 1, 2'b01, 1'b0, 1'b1, 1'b0, "t6_ptr0");
        tick();
        bus.done = 2'b01;
        bus.req  = '0;
        expect_at(cyc + 1, 2'b00, 1'b0, 1'b1, 1'b0, "t6_release");
        expect_at(cyc + 3, 2'b00, 1'b0, 1'b0, 1'b0, "t6_idle");
        tick();
        bus.done = '0;
        wait_to(cyc + 5);

        check("sb_empty", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
